// File: rtl/mat_result_streamer_if.sv
// Bundle of the matrix-capture and element-stream signals of the
// matrix result streamer. The slave modport is the streamer itself. The master
// modport is the environment around it: it supplies the matrix and consumes
// the element stream.
interface mat_result_streamer_if #(
    parameter int W    = 12,
    parameter int ROWS = 5,
    parameter int COLS = 4
);
    localparam int BUS_W = ROWS * COLS * W;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic [BUS_W-1:0] c_in;
    logic             c_valid;
    logic             c_ready;
    logic [W-1:0]     out_data;
    logic [ROW_W-1:0] out_row;
    logic [COL_W-1:0] out_col;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       frame_cnt;

    modport master (
        output c_in, c_valid, out_ready,
        input  c_ready, out_data, out_row, out_col, out_last, out_valid, frame_cnt
    );

    modport slave (
        input  c_in, c_valid, out_ready,
        output c_ready, out_data, out_row, out_col, out_last, out_valid, frame_cnt
    );
endinterface

// File: rtl/mat_result_streamer.sv
// Matrix result streamer: captures a packed ROWS x COLS result matrix in one
// cycle and streams it out element by element in row-major order over a
// valid/ready handshake. Capturing the next matrix during the last beat of the
// current one gives back-to-back frames with no bubble.
module mat_result_streamer #(
    parameter int W    = 12,
    parameter int ROWS = 5,
    parameter int COLS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mat_result_streamer_if.slave  s_if
);
    localparam int NELEM = ROWS * COLS;
    localparam int BUS_W = NELEM * W;
    localparam int K_W   = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(NELEM - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [W-1:0]     buf_q [NELEM];

    logic             capture;
    logic             c_ready;
    logic             is_last;

    // k reaching the final element marks the last beat of the frame
    always_comb begin
        is_last = (k_q == K_LAST);
    end

    // Next-state logic: capture, beat advance, end-of-frame handoff
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        row_d       = row_q;
        col_d       = col_q;
        frame_cnt_d = frame_cnt_q;
        c_ready     = 1'b0;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                c_ready = 1'b1;
                if (s_if.c_valid) begin
                    capture = 1'b1;
                    state_d = STREAM;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            STREAM: begin
                if (s_if.out_ready) begin
                    if (is_last) begin
                        // Last beat: the buffer is free, so a waiting matrix
                        // can be taken in the same cycle.
                        c_ready     = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        k_d         = '0;
                        row_d       = '0;
                        col_d       = '0;
                        if (s_if.c_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        k_d = k_q + K_W'(1);
                        if (col_q == COL_LAST) begin
                            col_d = '0;
                            row_d = row_q + ROW_W'(1);
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            row_q       <= row_d;
            col_q       <= col_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Frame buffer: unpack the row-major bus (element 0 in the MSBs); no reset needed
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < NELEM; i++) begin
                buf_q[i] <= s_if.c_in[BUS_W-1-W*i -: W];
            end
        end
    end

    // Stream outputs come only from registered state, so they hold during stalls
    assign s_if.out_valid = (state_q == STREAM);
    assign s_if.out_data  = (state_q == STREAM) ? buf_q[k_q] : '0;
    assign s_if.out_row   = row_q;
    assign s_if.out_col   = col_q;
    assign s_if.out_last  = (state_q == STREAM) && is_last;
    assign s_if.c_ready   = c_ready;
    assign s_if.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer: single frame, backpressure,
// back-to-back frames, ignored capture, mid-frame reset and frame counter wrap.
module tb_mat_result_streamer;
    localparam int W     = 12;
    localparam int ROWS  = 5;
    localparam int COLS  = 4;
    localparam int NELEM = ROWS * COLS;
    localparam int BUS_W = NELEM * W;

    // Element (r,c) = 16*r + c, written out by hand in row-major order
    localparam logic [W-1:0] EXP0 [NELEM] = '{
        12'h000, 12'h001, 12'h002, 12'h003,
        12'h010, 12'h011, 12'h012, 12'h013,
        12'h020, 12'h021, 12'h022, 12'h023,
        12'h030, 12'h031, 12'h032, 12'h033,
        12'h040, 12'h041, 12'h042, 12'h043
    };

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mat_result_streamer_if #(.W(W), .ROWS(ROWS), .COLS(COLS)) bus_if ();

    mat_result_streamer #(.W(W), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk  (clk),
        .rst  (rst),
        .s_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // pattern 0: 16*r+c table, 1: all 0xFFF, 2: distinct junk for ignored captures
    function automatic logic [W-1:0] elem(input int pat, input int k);
        case (pat)
            0:       elem = EXP0[k];
            1:       elem = 12'hFFF;
            default: elem = 12'hA50 ^ W'(k);
        endcase
    endfunction

    function automatic logic [BUS_W-1:0] pack(input int pat);
        logic [BUS_W-1:0] v;
        v = '0;
        for (int k = 0; k < NELEM; k++) begin
            v[BUS_W-1-W*k -: W] = elem(pat, k);
        end
        pack = v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus_if.c_valid   = 1'b0;
        bus_if.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Present a matrix for one cycle while idle; returns at the next negedge
    task automatic capture(input int pat);
        bus_if.c_in    = pack(pat);
        bus_if.c_valid = 1'b1;
        #1;
        chk("c_ready idle", bus_if.c_ready, 1);
        @(negedge clk);
        bus_if.c_valid = 1'b0;
    endtask

    // Consume nbeats elements starting at k=0; optional stalls, a junk capture
    // at beat glitch_k and a chained capture on the last beat
    task automatic stream(input int pat, input int nbeats, input bit stall,
                          input int glitch_k, input int next_pat, input bit chk_beats);
        for (int k = 0; k < nbeats; k++) begin
            if (stall && k > 0) begin
                bus_if.out_ready = 1'b0;
                bus_if.c_valid   = 1'b0;
                #1;
                chk($sformatf("stall valid k=%0d", k), bus_if.out_valid, 1);
                chk($sformatf("stall data k=%0d", k), bus_if.out_data, elem(pat, k));
                chk($sformatf("stall row k=%0d", k), bus_if.out_row, k / COLS);
                chk($sformatf("stall col k=%0d", k), bus_if.out_col, k % COLS);
                chk($sformatf("stall c_ready k=%0d", k), bus_if.c_ready, 0);
                @(negedge clk);
            end
            bus_if.out_ready = 1'b1;
            bus_if.c_valid   = 1'b0;
            if (k == glitch_k) begin
                bus_if.c_in    = pack(2);
                bus_if.c_valid = 1'b1;
            end
            if (k == NELEM - 1 && next_pat >= 0) begin
                bus_if.c_in    = pack(next_pat);
                bus_if.c_valid = 1'b1;
            end
            #1;
            if (chk_beats) begin
                chk($sformatf("valid k=%0d", k), bus_if.out_valid, 1);
                chk($sformatf("data k=%0d", k), bus_if.out_data, elem(pat, k));
                chk($sformatf("row k=%0d", k), bus_if.out_row, k / COLS);
                chk($sformatf("col k=%0d", k), bus_if.out_col, k % COLS);
                chk($sformatf("c_ready k=%0d", k), bus_if.c_ready, (k == NELEM - 1) ? 1 : 0);
            end
            chk($sformatf("last k=%0d", k), bus_if.out_last, (k == NELEM - 1) ? 1 : 0);
            @(negedge clk);
        end
        bus_if.out_ready = 1'b0;
        bus_if.c_valid   = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.c_in      = '0;
        bus_if.c_valid   = 1'b0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst out_valid", bus_if.out_valid, 0);
        chk("rst out_last", bus_if.out_last, 0);
        chk("rst out_data", bus_if.out_data, 0);
        chk("rst out_row", bus_if.out_row, 0);
        chk("rst out_col", bus_if.out_col, 0);
        chk("rst frame_cnt", bus_if.frame_cnt, 0);
        chk("rst c_ready", bus_if.c_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // out_ready while idle has no effect
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        chk("idle ready valid", bus_if.out_valid, 0);
        chk("idle ready cnt", bus_if.frame_cnt, 0);
        bus_if.out_ready = 1'b0;

        // Single frame at full rate
        capture(0);
        stream(0, NELEM, 1'b0, -1, -1, 1'b1);
        chk("single valid after", bus_if.out_valid, 0);
        chk("single frame_cnt", bus_if.frame_cnt, 1);

        // Backpressure: alternating ready
        capture(0);
        stream(0, NELEM, 1'b1, -1, -1, 1'b1);
        chk("bp valid after", bus_if.out_valid, 0);
        chk("bp frame_cnt", bus_if.frame_cnt, 2);

        // Back-to-back: second matrix captured on the last beat of the first
        do_reset();
        capture(0);
        stream(0, NELEM, 1'b0, -1, 1, 1'b1);
        stream(1, NELEM, 1'b0, -1, -1, 1'b1);
        chk("b2b valid after", bus_if.out_valid, 0);
        chk("b2b frame_cnt", bus_if.frame_cnt, 2);

        // Ignored capture at beat 7
        capture(0);
        stream(0, NELEM, 1'b0, 7, -1, 1'b1);
        chk("ign frame_cnt", bus_if.frame_cnt, 3);

        // Reset mid-frame at beat 10
        capture(1);
        stream(1, 10, 1'b0, -1, -1, 1'b1);
        chk("pre-rst valid", bus_if.out_valid, 1);
        chk("pre-rst data", bus_if.out_data, 12'hFFF);
        rst = 1'b1;
        #1;
        chk("mid-rst out_valid", bus_if.out_valid, 0);
        chk("mid-rst out_data", bus_if.out_data, 0);
        chk("mid-rst out_row", bus_if.out_row, 0);
        chk("mid-rst frame_cnt", bus_if.frame_cnt, 0);
        chk("mid-rst c_ready", bus_if.c_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        capture(0);
        stream(0, NELEM, 1'b0, -1, -1, 1'b1);
        chk("post-rst frame_cnt", bus_if.frame_cnt, 1);

        // Frame counter wrap over 256 frames
        do_reset();
        for (int f = 0; f < 256; f++) begin
            capture(f % 2);
            stream(f % 2, NELEM, 1'b0, -1, -1, 1'b0);
            if (f == 254) chk("wrap cnt 255", bus_if.frame_cnt, 255);
            if (f == 255) chk("wrap cnt 0", bus_if.frame_cnt, 0);
        end
        chk("wrap valid after", bus_if.out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mat_result_streamer.md
MAT_RESULT_STREAMER -- requirements
Module: mat_result_streamer

Interface
REQ-001 SHALL have parameter W, default 12, element width in bits.
REQ-002 SHALL have parameter ROWS, default 5, result matrix rows.
REQ-003 SHALL have parameter COLS, default 4, result matrix columns.
REQ-004 SHALL have one clock and one reset: asynchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 c_in  input  ROWS*COLS*W (240)  packed result matrix, row-major; element (r,c) at bits [N-1-W*(r*COLS+c) -: W], where N is the bus width.
REQ-008 c_valid  input  1  c_in holds a complete matrix to capture.
REQ-009 c_ready  output  1  block can capture a matrix this cycle.
REQ-010 out_data  output  W  current streamed element.
REQ-011 out_row  output  3  row index of out_data.
REQ-012 out_col  output  2  column index of out_data.
REQ-013 out_last  output  1  out_data is element (ROWS-1,COLS-1).
REQ-014 out_valid  output  1  out_data/out_row/out_col/out_last are valid.
REQ-015 out_ready  input  1  downstream accepts the element this cycle.
REQ-016 frame_cnt  output  8  count of fully streamed matrices, modulo 256.

Function
REQ-017 SHALL implement FSM states IDLE and STREAM.
REQ-018 Capture occurs on a rising edge with c_valid && c_ready.
- c_in is copied into an internal frame buffer.
- Element index k is set to 0.
- The FSM moves to STREAM.
REQ-019 c_ready SHALL be 1 in IDLE.
REQ-020 In STREAM, c_ready SHALL be 1 only when out_valid && out_ready && out_last (last-beat handoff); otherwise 0.
REQ-021 out_valid SHALL be 1 exactly when in STREAM; first element presented the cycle after capture (latency 1).
REQ-022 out_data SHALL equal buffered element k; out_row = k / COLS, out_col = k mod COLS; all registered or derived from registered k only.
REQ-023 A beat transfers when out_valid && out_ready; then k increments by 1.
REQ-024 While out_valid && !out_ready, out_data/out_row/out_col/out_last SHALL hold stable.
REQ-025 out_last SHALL be 1 exactly when k = ROWS*COLS-1 (19).
REQ-026 On transfer of the last beat:
- frame_cnt increments, wrapping 255 -> 0.
- If c_valid is also high that cycle, the new matrix is captured, k = 0, and the FSM stays in STREAM (zero-bubble back-to-back).
- Otherwise the FSM returns to IDLE.
REQ-027 c_valid while c_ready = 0 SHALL be ignored; the buffer SHALL NOT change mid-frame.
REQ-028 Index arithmetic SHALL be unsigned; k SHALL never exceed ROWS*COLS-1.
REQ-029 out_ready while out_valid = 0 SHALL have no effect.

Reset
REQ-030 rst asserted SHALL immediately force:
- FSM = IDLE, k = 0.
- out_valid = 0, out_last = 0.
- out_data = 0, out_row = 0, out_col = 0.
- frame_cnt = 0; c_ready = 1 once in IDLE.
REQ-031 rst asserted mid-frame SHALL abandon the frame without incrementing frame_cnt; the first capture after deassertion SHALL stream from k = 0.
REQ-032 The frame buffer contents need not be cleared by reset.

Verification
REQ-033 Single frame: c_in element(r,c) = 16*r+c, c_valid for 1 cycle, out_ready = 1 -> 20 beats on consecutive cycles starting 1 cycle after capture, data 0x000,0x001,0x002,0x003,0x010,...,0x043; out_last only on beat 20; frame_cnt = 1.
REQ-034 Backpressure: out_ready toggles 1,0,1,0 -> each element held while stalled; 20 beats in order; no duplication or loss.
REQ-035 Back-to-back: second matrix (all elements 0xFFF) with c_valid high during the last beat of frame 1 -> first 0xFFF beat the very next cycle with out_valid continuous; frame_cnt = 2 after both frames.
REQ-036 Ignored capture: c_valid pulsed at beat 7 with different c_in -> frame 1 output unchanged; c_ready = 0 at that cycle.
REQ-037 Reset mid-frame: rst pulsed at beat 10 -> out_valid = 0 asynchronously; frame_cnt = 0; next capture streams from (0,0).
REQ-038 Wrap: 256 frames streamed -> frame_cnt = 0 after the 256th last beat.
